i2c_regmap_ctrl: RTL and testbench
==================================

Name: i2c_regmap_ctrl

Overview:
Register-map controller that sequences the I2C slave byte datapath. It sits between the slave's received-byte/transmit-byte interface and a small 8-bit register bank. The first byte written after a start sets a register pointer. Later written bytes update registers with auto-increment, and read phases stream registers out through the slave's transmit shifter. A local hardware write port shares the bank with the bus, and the bus has priority.

Parameters:
NREGS, 8, number of 8-bit registers (power of 2, 2..256)
ADDR_W, $clog2(NREGS), pointer width (localparam, derived, not overridable)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
bus_start  in  1  one-cycle pulse: start or repeated start addressed to this slave
bus_stop  in  1  one-cycle pulse: stop condition
rx_valid  in  1  one-cycle pulse: rx_data holds a newly received byte
rx_data  in  8  received byte
tx_active  in  1  slave is in master-read (transmit) phase
tx_empty  in  1  slave transmit shifter empty, ready for a byte
tx_data  out  8  byte presented to the slave shifter
tx_load  out  1  one-cycle load strobe for tx_data
hw_we  in  1  local write request
hw_addr  in  ADDR_W  local write address
hw_wdata  in  8  local write data
hw_ack  out  1  local write accepted this cycle
regs  out  NREGS*8  flattened register contents; reg i is at [8i+7:8i]
ptr  out  ADDR_W  current register pointer
bus_wr  out  1  one-cycle pulse: bus write committed this cycle (for downstream side effects)

Behaviour:
- Reset (synchronous, highest priority, any state): all regs=0, ptr=0, state=IDLE, tx_data=0, tx_load=0, hw_ack=0, bus_wr=0.
- FSM states: IDLE, PTR, WDATA, RD, RD_HOLD.
- IDLE: bus_start -> PTR. All other bus inputs are ignored.
- PTR:
  - rx_valid -> ptr<=rx_data[ADDR_W-1:0] (upper bits dropped), go to WDATA.
  - tx_active&tx_empty -> go to RD with ptr unchanged (current-address read).
- WDATA: each rx_valid writes reg[ptr]<=rx_data, pulses bus_wr, and sets ptr<=ptr+1 (wraps NREGS-1 -> 0). The write is visible on regs the next cycle.
- RD: on tx_active&tx_empty, tx_data<=reg[ptr] and tx_load=1 for that single cycle; ptr<=ptr+1 (wraps); go to RD_HOLD.
- RD_HOLD: stays exactly 1 cycle so the shifter can deassert tx_empty, then returns to RD. Exactly one tx_load per empty slot.
- Global transitions from PTR/WDATA/RD/RD_HOLD:
  - bus_stop -> IDLE.
  - bus_start -> PTR.
  - ptr is preserved across both, which supports the write-pointer/repeated-start/read sequence.
- Simultaneous events:
  - bus_start with rx_valid: start wins and the byte is discarded.
  - bus_stop with rx_valid in WDATA: the byte is written first, then the FSM goes to IDLE.
  - bus_stop with tx load in RD: no tx_load is issued.
- Arbitration:
  - hw_we is accepted (hw_ack=1, same cycle, write takes effect next edge) unless a bus write commits in the same cycle. In that case hw_ack=0 and the requester must hold and retry.
  - hw writes never move ptr.
  - A hw write to reg[ptr] in the same cycle as tx_load: tx_data carries the old value.
- Latency: rx_valid -> register updated 1 cycle later. tx_active&tx_empty -> tx_load in the same cycle (registered data, combinational strobe from registered state).

Optional Feature:
I2C_REGMAP_WP_EN
- Defined: adds input wp_mask[NREGS-1:0] and output wp_hit (1 bit). A bus write to reg[ptr] with wp_mask[ptr]=1 is dropped: no bus_wr, ptr still increments, wp_hit pulses 1 cycle. hw writes ignore the mask.
- Undefined: neither port exists, and all bus writes commit.

Decomposition:
- Package i2c_regmap_pkg holds:
  - typedef byte_t (logic [7:0]);
  - the state enum regmap_state_t;
  - the constant DEFAULT_NREGS=8.
- Sub-module regmap_bank: NREGS x 8 storage with two write ports (bus port priority, hw port with ack) and flat read output. The FSM and pointer stay in i2c_regmap_ctrl.

Test Plan:
- Pointer write: start, rx 0x03, rx 0xA5, rx 0x5A, stop -> reg3=0xA5, reg4=0x5A, ptr=5, two bus_wr pulses, state IDLE.
- Pointer-then-read: start, rx 0x06, start, tx_active=1 with tx_empty pulsed four times -> tx_data sequence reg6, reg7, reg0, reg1 (wrap); exactly four tx_load pulses.
- Collision: hw_we addr 2 data 0x11 in the same cycle as a bus write to reg5 -> hw_ack=0, reg2 unchanged. Retry next cycle -> hw_ack=1, reg2=0x11.
- Oversized pointer: NREGS=8, rx 0xFD as pointer -> ptr=5.
- Edge cases: bus_start coincident with rx_valid 0x44 -> byte dropped, state PTR. Reset asserted mid-RD -> all outputs and regs 0 on the next cycle.
- With I2C_REGMAP_WP_EN: wp_mask=0x01, ptr 0, write 0xFF, 0x22 -> reg0 unchanged, wp_hit once, reg1=0x22.

Source files
------------

// File: rtl/i2c_regmap_pkg.sv
// i2c_regmap_pkg: shared types and constants for the I2C register-map controller.
//   byte_t          - 8-bit data byte
//   regmap_state_t  - controller FSM states
//   DEFAULT_NREGS   - default register count
package i2c_regmap_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        StIdle,
        StPtr,
        StWdata,
        StRd,
        StRdHold
    } regmap_state_t;

    localparam int unsigned DEFAULT_NREGS = 8;

endpackage

// File: rtl/regmap_bank.sv
// regmap_bank: NREGS x 8-bit register storage with two write ports.
//   i_clock, i_reset        - clock, synchronous active-high reset (clears all registers)
//   i_bus_we/addr/wdata     - bus write port, always wins
//   i_hw_we/addr/wdata      - local write port, accepted only when the bus port is idle
//   o_hw_ack                - local write accepted this cycle
//   o_regs                  - flattened contents, register i at [8i+7:8i]
module regmap_bank
    import i2c_regmap_pkg::*;
#(
    parameter  int unsigned NREGS  = DEFAULT_NREGS,
    localparam int unsigned ADDR_W = $clog2(NREGS)
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_bus_we,
    input  logic [ADDR_W-1:0]  i_bus_addr,
    input  logic [7:0]         i_bus_wdata,
    input  logic               i_hw_we,
    input  logic [ADDR_W-1:0]  i_hw_addr,
    input  logic [7:0]         i_hw_wdata,
    output logic               o_hw_ack,
    output logic [NREGS*8-1:0] o_regs
);

    byte_t [NREGS-1:0] r_mem;

    // Any committing bus write blocks the local port, regardless of address.
    assign o_hw_ack = i_hw_we & ~i_bus_we & ~i_reset;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_mem <= '0;
        end else begin
            if (o_hw_ack) begin
                r_mem[i_hw_addr] <= i_hw_wdata;
            end
            if (i_bus_we) begin
                r_mem[i_bus_addr] <= i_bus_wdata;
            end
        end
    end

    assign o_regs = r_mem;

endmodule

// File: rtl/i2c_regmap_ctrl.sv
// i2c_regmap_ctrl: sequences an I2C slave byte datapath onto a small register bank.
// First byte after a start loads the pointer, later bytes write with auto-increment,
// read phases stream registers to the slave transmit shifter. A local write port shares
// the bank; the bus has priority.
//   i_clock, i_reset          - clock, synchronous active-high reset
//   i_bus_start, i_bus_stop   - start/repeated-start and stop pulses
//   i_rx_valid, i_rx_data     - received byte strobe and data
//   i_tx_active, i_tx_empty   - master-read phase, shifter ready for a byte
//   o_tx_data, o_tx_load      - byte for the shifter and its load strobe
//   i_hw_we/addr/wdata, o_hw_ack - local write port and acceptance
//   o_regs, o_ptr, o_bus_wr   - register contents, pointer, bus write commit pulse
// Optional (macro I2C_REGMAP_WP_EN): i_wp_mask per-register bus write protect,
//   o_wp_hit pulses when a protected bus write is dropped.
module i2c_regmap_ctrl
    import i2c_regmap_pkg::*;
#(
    parameter  int unsigned NREGS  = DEFAULT_NREGS,
    localparam int unsigned ADDR_W = $clog2(NREGS)
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_bus_start,
    input  logic               i_bus_stop,
    input  logic               i_rx_valid,
    input  logic [7:0]         i_rx_data,
    input  logic               i_tx_active,
    input  logic               i_tx_empty,
    output logic [7:0]         o_tx_data,
    output logic               o_tx_load,
    input  logic               i_hw_we,
    input  logic [ADDR_W-1:0]  i_hw_addr,
    input  logic [7:0]         i_hw_wdata,
    output logic               o_hw_ack,
    output logic [NREGS*8-1:0] o_regs,
    output logic [ADDR_W-1:0]  o_ptr,
    output logic               o_bus_wr
`ifdef I2C_REGMAP_WP_EN
    ,
    input  logic [NREGS-1:0]   i_wp_mask,
    output logic               o_wp_hit
`endif
);

    regmap_state_t     r_state;
    regmap_state_t     w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_nxt;
    byte_t             r_tx_data;
    byte_t             w_tx_data_nxt;
    logic              w_tx_load;
    logic              w_data_byte;
    logic              w_wp_blk;
    logic              w_bus_we;
    logic              w_rx_ok;
    logic              w_tx_slot;
    byte_t             w_rd_byte;
    logic [NREGS*8-1:0] w_regs;

`ifdef I2C_REGMAP_WP_EN
    assign w_wp_blk = i_wp_mask[r_ptr];
    assign o_wp_hit = w_data_byte & w_wp_blk & ~i_reset;
`else
    assign w_wp_blk = 1'b0;
`endif

    // A start coincident with a received byte wins; the byte is discarded.
    assign w_rx_ok   = i_rx_valid & ~i_bus_start;
    assign w_tx_slot = i_tx_active & i_tx_empty;
    assign w_rd_byte = w_regs[{r_ptr, 3'b000} +: 8];
    assign w_bus_we  = w_data_byte & ~w_wp_blk;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state   <= StIdle;
            r_ptr     <= '0;
            r_tx_data <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_tx_data <= w_tx_data_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_tx_data_nxt = r_tx_data;
        w_tx_load     = 1'b0;
        w_data_byte   = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (i_bus_start) begin
                    w_state_nxt = StPtr;
                end
            end
            StPtr: begin
                if (w_rx_ok) begin
                    w_ptr_nxt   = i_rx_data[ADDR_W-1:0];
                    w_state_nxt = StWdata;
                end else if (w_tx_slot) begin
                    w_state_nxt = StRd;
                end
            end
            StWdata: begin
                // Pointer advances even when the write is dropped by protection.
                if (w_rx_ok) begin
                    w_data_byte = 1'b1;
                    w_ptr_nxt   = r_ptr + 1'b1;
                end
            end
            StRd: begin
                if (w_tx_slot && !i_bus_stop && !i_bus_start) begin
                    w_tx_load     = 1'b1;
                    w_tx_data_nxt = w_rd_byte;
                    w_ptr_nxt     = r_ptr + 1'b1;
                    w_state_nxt   = StRdHold;
                end
            end
            StRdHold: begin
                // One dead cycle lets the shifter drop tx_empty after the load.
                w_state_nxt = StRd;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase

        // Stop/start override the per-state transition but keep the pointer.
        if (r_state != StIdle) begin
            if (i_bus_stop) begin
                w_state_nxt = StIdle;
            end else if (i_bus_start) begin
                w_state_nxt = StPtr;
            end
        end
    end

    regmap_bank #(
        .NREGS (NREGS)
    ) u_bank (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_bus_we    (w_bus_we),
        .i_bus_addr  (r_ptr),
        .i_bus_wdata (i_rx_data),
        .i_hw_we     (i_hw_we),
        .i_hw_addr   (i_hw_addr),
        .i_hw_wdata  (i_hw_wdata),
        .o_hw_ack    (o_hw_ack),
        .o_regs      (w_regs)
    );

    assign o_regs    = w_regs;
    assign o_ptr     = r_ptr;
    assign o_tx_data = r_tx_data;
    assign o_tx_load = w_tx_load & ~i_reset;
    assign o_bus_wr  = w_bus_we & ~i_reset;

endmodule

// File: tb/tb_i2c_regmap_ctrl.sv
// tb_i2c_regmap_ctrl: self-checking bench for i2c_regmap_ctrl. Keeps a transaction-level
// model (register array plus pointer) and compares directed and random sequences.
module tb_i2c_regmap_ctrl;

    localparam int NREGS = 8;
    localparam int AW    = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             bus_start = 1'b0;
    logic             bus_stop = 1'b0;
    logic             rx_valid = 1'b0;
    logic [7:0]       rx_data = '0;
    logic             tx_active = 1'b0;
    logic             tx_empty = 1'b0;
    logic [7:0]       tx_data;
    logic             tx_load;
    logic             hw_we = 1'b0;
    logic [AW-1:0]    hw_addr = '0;
    logic [7:0]       hw_wdata = '0;
    logic             hw_ack;
    logic [NREGS*8-1:0] regs;
    logic [AW-1:0]    ptr;
    logic             bus_wr;
`ifdef I2C_REGMAP_WP_EN
    logic [NREGS-1:0] wp_mask = '0;
    logic             wp_hit;
`endif

    int vectors = 0;
    int miscompares = 0;
    int bus_wr_cnt = 0;
    int load_cnt = 0;

    logic [7:0] m_regs [NREGS];
    int         m_ptr;

    i2c_regmap_ctrl #(
        .NREGS (NREGS)
    ) dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_bus_start (bus_start),
        .i_bus_stop  (bus_stop),
        .i_rx_valid  (rx_valid),
        .i_rx_data   (rx_data),
        .i_tx_active (tx_active),
        .i_tx_empty  (tx_empty),
        .o_tx_data   (tx_data),
        .o_tx_load   (tx_load),
        .i_hw_we     (hw_we),
        .i_hw_addr   (hw_addr),
        .i_hw_wdata  (hw_wdata),
        .o_hw_ack    (hw_ack),
        .o_regs      (regs),
        .o_ptr       (ptr),
        .o_bus_wr    (bus_wr)
`ifdef I2C_REGMAP_WP_EN
        ,
        .i_wp_mask   (wp_mask),
        .o_wp_hit    (wp_hit)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus_wr === 1'b1) bus_wr_cnt++;
        if (tx_load === 1'b1) load_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [7:0] reg_at(int i);
        return regs[8*i +: 8];
    endfunction

    // Advance one clock; pulse inputs are cleared after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        bus_start = 1'b0;
        bus_stop  = 1'b0;
        rx_valid  = 1'b0;
        hw_we     = 1'b0;
    endtask

    task automatic cyc_start();
        bus_start = 1'b1;
        tick();
    endtask

    task automatic cyc_stop();
        bus_stop = 1'b1;
        tick();
    endtask

    task automatic cyc_rx(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        hw_we = 1'b1;
        hw_addr = 3'd1;
        hw_wdata = 8'h5C;
        @(negedge clk);
        vectors++;
        if (hw_ack !== 1'b0 || tx_load !== 1'b0 || bus_wr !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_strobes: ack=%b load=%b wr=%b want 0", hw_ack, tx_load, bus_wr);
        end
        tick();
        tick();
        vectors++;
        if (regs !== '0 || ptr !== '0 || tx_data !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_state: regs=%h ptr=%0d tx=%h want 0", regs, ptr, tx_data);
        end
        rst = 1'b0;
        for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;
        m_ptr = 0;
        tick();
    endtask

    task automatic test_ptr_write();
        int c0;
        c0 = bus_wr_cnt;
        cyc_start();
        cyc_rx(8'h03);
        cyc_rx(8'hA5);
        cyc_rx(8'h5A);
        cyc_stop();
        m_regs[3] = 8'hA5;
        m_regs[4] = 8'h5A;
        m_ptr = 5;
        vectors++;
        if (reg_at(3) !== 8'hA5 || reg_at(4) !== 8'h5A) begin
            miscompares++;
            $display("FAIL ptr_write_regs: r3=%h r4=%h want a5 5a", reg_at(3), reg_at(4));
        end
        vectors++;
        if (ptr !== 3'd5) begin
            miscompares++;
            $display("FAIL ptr_write_ptr: got %0d want 5", ptr);
        end
        vectors++;
        if (bus_wr_cnt - c0 != 2) begin
            miscompares++;
            $display("FAIL ptr_write_pulses: got %0d want 2", bus_wr_cnt - c0);
        end
        // Idle must ignore received bytes.
        rx_valid = 1'b1;
        rx_data = 8'h77;
        @(negedge clk);
        vectors++;
        if (bus_wr !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_ignore: bus_wr=%b want 0", bus_wr);
        end
        tick();
        vectors++;
        if (reg_at(5) !== m_regs[5] || ptr !== 3'd5) begin
            miscompares++;
            $display("FAIL idle_ignore_state: r5=%h ptr=%0d want %h 5", reg_at(5), ptr, m_regs[5]);
        end
    endtask

    task automatic test_ptr_read();
        int c0;
        int got;
        int hold;
        logic [7:0] exp;
        for (int k = 0; k < 4; k++) begin
            hw_we = 1'b1;
            hw_addr = 3'((6 + k) % NREGS);
            hw_wdata = 8'($urandom_range(1, 255));
            @(negedge clk);
            vectors++;
            if (hw_ack !== 1'b1) begin
                miscompares++;
                $display("FAIL hw_idle_ack: got %b want 1", hw_ack);
            end
            m_regs[hw_addr] = hw_wdata;
            tick();
        end
        c0 = load_cnt;
        cyc_start();
        cyc_rx(8'h06);
        m_ptr = 6;
        cyc_start();
        tx_active = 1'b1;
        tx_empty = 1'b1;
        got = 0;
        for (int c = 0; c < 100 && got < 4; c++) begin
            @(negedge clk);
            if (tx_load === 1'b1) begin
                exp = m_regs[m_ptr];
                m_ptr = (m_ptr + 1) % NREGS;
                got++;
                tick();
                vectors++;
                if (tx_data !== exp) begin
                    miscompares++;
                    $display("FAIL ptr_read_data[%0d]: got %h want %h", got, tx_data, exp);
                end
                tx_empty = 1'b0;
                hold = $urandom_range(1, 3);
                repeat (hold) tick();
                tx_empty = 1'b1;
            end else begin
                tick();
            end
        end
        tx_empty = 1'b0;
        tx_active = 1'b0;
        tick();
        cyc_stop();
        vectors++;
        if (load_cnt - c0 != 4) begin
            miscompares++;
            $display("FAIL ptr_read_loads: got %0d want 4", load_cnt - c0);
        end
        vectors++;
        if (ptr !== 3'(m_ptr)) begin
            miscompares++;
            $display("FAIL ptr_read_ptr: got %0d want %0d", ptr, m_ptr);
        end
    endtask

    task automatic test_collision();
        logic [7:0] old2;
        old2 = m_regs[2];
        cyc_start();
        cyc_rx(8'h05);
        rx_valid = 1'b1;
        rx_data = 8'hC3;
        hw_we = 1'b1;
        hw_addr = 3'd2;
        hw_wdata = 8'h11;
        @(negedge clk);
        vectors++;
        if (hw_ack !== 1'b0 || bus_wr !== 1'b1) begin
            miscompares++;
            $display("FAIL collision_ack: ack=%b wr=%b want 0 1", hw_ack, bus_wr);
        end
        tick();
        m_regs[5] = 8'hC3;
        vectors++;
        if (reg_at(2) !== old2 || reg_at(5) !== 8'hC3) begin
            miscompares++;
            $display("FAIL collision_regs: r2=%h r5=%h want %h c3", reg_at(2), reg_at(5), old2);
        end
        hw_we = 1'b1;
        hw_addr = 3'd2;
        hw_wdata = 8'h11;
        @(negedge clk);
        vectors++;
        if (hw_ack !== 1'b1) begin
            miscompares++;
            $display("FAIL retry_ack: got %b want 1", hw_ack);
        end
        tick();
        m_regs[2] = 8'h11;
        vectors++;
        if (reg_at(2) !== 8'h11) begin
            miscompares++;
            $display("FAIL retry_reg: got %h want 11", reg_at(2));
        end
        cyc_stop();
        m_ptr = 6;
    endtask

    task automatic test_oversized_ptr();
        cyc_start();
        cyc_rx(8'hFD);
        m_ptr = 8'hFD % NREGS;
        vectors++;
        if (ptr !== 3'(m_ptr)) begin
            miscompares++;
            $display("FAIL oversized_ptr: got %0d want %0d", ptr, m_ptr);
        end
        cyc_stop();
    endtask

    task automatic test_start_with_rx();
        cyc_start();
        bus_start = 1'b1;
        rx_valid = 1'b1;
        rx_data = 8'h44;
        @(negedge clk);
        vectors++;
        if (bus_wr !== 1'b0) begin
            miscompares++;
            $display("FAIL start_rx_wr: got %b want 0", bus_wr);
        end
        tick();
        vectors++;
        if (ptr !== 3'(m_ptr)) begin
            miscompares++;
            $display("FAIL start_rx_ptr: got %0d want %0d", ptr, m_ptr);
        end
        // Still in the pointer phase: next byte is a pointer, not data.
        rx_valid = 1'b1;
        rx_data = 8'h02;
        @(negedge clk);
        vectors++;
        if (bus_wr !== 1'b0) begin
            miscompares++;
            $display("FAIL start_rx_ptrbyte_wr: got %b want 0", bus_wr);
        end
        tick();
        m_ptr = 2;
        vectors++;
        if (ptr !== 3'd2) begin
            miscompares++;
            $display("FAIL start_rx_newptr: got %0d want 2", ptr);
        end
        cyc_stop();
        for (int i = 0; i < NREGS; i++) begin
            vectors++;
            if (reg_at(i) !== m_regs[i]) begin
                miscompares++;
                $display("FAIL start_rx_regs[%0d]: got %h want %h", i, reg_at(i), m_regs[i]);
            end
        end
    endtask

    task automatic test_stop_with_rx();
        cyc_start();
        cyc_rx(8'h01);
        bus_stop = 1'b1;
        rx_valid = 1'b1;
        rx_data = 8'h9E;
        @(negedge clk);
        vectors++;
        if (bus_wr !== 1'b1) begin
            miscompares++;
            $display("FAIL stop_rx_wr: got %b want 1", bus_wr);
        end
        tick();
        m_regs[1] = 8'h9E;
        m_ptr = 2;
        vectors++;
        if (reg_at(1) !== 8'h9E || ptr !== 3'd2) begin
            miscompares++;
            $display("FAIL stop_rx_state: r1=%h ptr=%0d want 9e 2", reg_at(1), ptr);
        end
        rx_valid = 1'b1;
        rx_data = 8'h99;
        @(negedge clk);
        vectors++;
        if (bus_wr !== 1'b0) begin
            miscompares++;
            $display("FAIL stop_rx_idle: got %b want 0", bus_wr);
        end
        tick();
    endtask

    task automatic test_stop_with_tx();
        cyc_start();
        cyc_rx(8'h03);
        m_ptr = 3;
        cyc_start();
        tx_active = 1'b1;
        tx_empty = 1'b1;
        tick();
        bus_stop = 1'b1;
        @(negedge clk);
        vectors++;
        if (tx_load !== 1'b0) begin
            miscompares++;
            $display("FAIL stop_tx_load: got %b want 0", tx_load);
        end
        tick();
        tx_active = 1'b0;
        tx_empty = 1'b0;
        vectors++;
        if (ptr !== 3'd3) begin
            miscompares++;
            $display("FAIL stop_tx_ptr: got %0d want 3", ptr);
        end
        tick();
    endtask

    task automatic test_hw_during_load();
        logic [7:0] old_v;
        logic [7:0] new_v;
        cyc_start();
        cyc_rx(8'h04);
        m_ptr = 4;
        cyc_start();
        tx_active = 1'b1;
        tx_empty = 1'b1;
        tick();
        old_v = m_regs[4];
        new_v = ~old_v;
        hw_we = 1'b1;
        hw_addr = 3'd4;
        hw_wdata = new_v;
        @(negedge clk);
        vectors++;
        if (tx_load !== 1'b1 || hw_ack !== 1'b1) begin
            miscompares++;
            $display("FAIL hw_load_strobes: load=%b ack=%b want 1 1", tx_load, hw_ack);
        end
        tick();
        tx_empty = 1'b0;
        m_regs[4] = new_v;
        m_ptr = 5;
        vectors++;
        if (tx_data !== old_v) begin
            miscompares++;
            $display("FAIL hw_load_old: got %h want %h", tx_data, old_v);
        end
        vectors++;
        if (reg_at(4) !== new_v) begin
            miscompares++;
            $display("FAIL hw_load_reg: got %h want %h", reg_at(4), new_v);
        end
        tx_active = 1'b0;
        cyc_stop();
    endtask

    task automatic test_random();
        int n;
        int got;
        int hold;
        logic [7:0] exp;
        for (int t = 0; t < 24; t++) begin
            n = $urandom_range(1, 6);
            if ($urandom_range(0, 1) == 0) begin
                bus_start = 1'b1;
                cyc_rx_skip: begin end
                tick();
                rx_valid = 1'b1;
                rx_data = 8'($urandom);
                m_ptr = rx_data % NREGS;
                tick();
                for (int i = 0; i < n; i++) begin
                    if ($urandom_range(0, 2) == 0) begin
                        hw_we = 1'b1;
                        hw_addr = 3'($urandom_range(0, NREGS - 1));
                        hw_wdata = 8'($urandom);
                        @(negedge clk);
                        vectors++;
                        if (hw_ack !== 1'b1 || bus_wr !== 1'b0) begin
                            miscompares++;
                            $display("FAIL rand_gap: ack=%b wr=%b want 1 0", hw_ack, bus_wr);
                        end
                        m_regs[hw_addr] = hw_wdata;
                        tick();
                    end
                    rx_valid = 1'b1;
                    rx_data = 8'($urandom);
                    hw_we = 1'($urandom_range(0, 1));
                    hw_addr = 3'($urandom_range(0, NREGS - 1));
                    hw_wdata = 8'($urandom);
                    @(negedge clk);
                    vectors++;
                    if (bus_wr !== 1'b1 || hw_ack !== 1'b0) begin
                        miscompares++;
                        $display("FAIL rand_wr: wr=%b ack=%b want 1 0", bus_wr, hw_ack);
                    end
                    m_regs[m_ptr] = rx_data;
                    m_ptr = (m_ptr + 1) % NREGS;
                    tick();
                end
                cyc_stop();
            end else begin
                cyc_start();
                if ($urandom_range(0, 2) != 0) begin
                    cyc_rx(8'($urandom));
                    m_ptr = rx_data % NREGS;
                    cyc_start();
                end
                tx_active = 1'b1;
                tx_empty = 1'b1;
                got = 0;
                for (int c = 0; c < 100 && got < n; c++) begin
                    @(negedge clk);
                    if (tx_load === 1'b1) begin
                        exp = m_regs[m_ptr];
                        m_ptr = (m_ptr + 1) % NREGS;
                        got++;
                        tick();
                        vectors++;
                        if (tx_data !== exp) begin
                            miscompares++;
                            $display("FAIL rand_rd_data: got %h want %h", tx_data, exp);
                        end
                        tx_empty = 1'b0;
                        hold = $urandom_range(1, 3);
                        repeat (hold) tick();
                        tx_empty = 1'b1;
                    end else begin
                        tick();
                    end
                end
                vectors++;
                if (got != n) begin
                    miscompares++;
                    $display("FAIL rand_rd_count: got %0d want %0d", got, n);
                end
                tx_active = 1'b0;
                tx_empty = 1'b0;
                cyc_stop();
            end
            vectors++;
            if (ptr !== 3'(m_ptr)) begin
                miscompares++;
                $display("FAIL rand_ptr: got %0d want %0d", ptr, m_ptr);
            end
            for (int i = 0; i < NREGS; i++) begin
                vectors++;
                if (reg_at(i) !== m_regs[i]) begin
                    miscompares++;
                    $display("FAIL rand_regs[%0d]: got %h want %h", i, reg_at(i), m_regs[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_rd();
        cyc_start();
        tx_active = 1'b1;
        tx_empty = 1'b1;
        tick();
        tick();
        tx_empty = 1'b0;
        tick();
        tx_empty = 1'b1;
        rst = 1'b1;
        hw_we = 1'b1;
        hw_addr = 3'd0;
        hw_wdata = 8'hEE;
        @(negedge clk);
        vectors++;
        if (tx_load !== 1'b0 || hw_ack !== 1'b0 || bus_wr !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_rd_strobes: load=%b ack=%b wr=%b want 0", tx_load, hw_ack, bus_wr);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;
        m_ptr = 0;
        vectors++;
        if (regs !== '0 || ptr !== '0 || tx_data !== 8'h00) begin
            miscompares++;
            $display("FAIL rst_rd_state: regs=%h ptr=%0d tx=%h want 0", regs, ptr, tx_data);
        end
        @(negedge clk);
        vectors++;
        if (tx_load !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_rd_idle_load: got %b want 0", tx_load);
        end
        tx_active = 1'b0;
        tx_empty = 1'b0;
        tick();
    endtask

`ifdef I2C_REGMAP_WP_EN
    task automatic test_write_protect();
        int c0;
        wp_mask = 8'h01;
        cyc_start();
        cyc_rx(8'h00);
        m_ptr = 0;
        c0 = bus_wr_cnt;
        rx_valid = 1'b1;
        rx_data = 8'hFF;
        @(negedge clk);
        vectors++;
        if (wp_hit !== 1'b1 || bus_wr !== 1'b0) begin
            miscompares++;
            $display("FAIL wp_drop: hit=%b wr=%b want 1 0", wp_hit, bus_wr);
        end
        tick();
        rx_valid = 1'b1;
        rx_data = 8'h22;
        @(negedge clk);
        vectors++;
        if (wp_hit !== 1'b0 || bus_wr !== 1'b1) begin
            miscompares++;
            $display("FAIL wp_pass: hit=%b wr=%b want 0 1", wp_hit, bus_wr);
        end
        tick();
        m_regs[1] = 8'h22;
        m_ptr = 2;
        cyc_stop();
        vectors++;
        if (reg_at(0) !== m_regs[0] || reg_at(1) !== 8'h22 || ptr !== 3'd2) begin
            miscompares++;
            $display("FAIL wp_state: r0=%h r1=%h ptr=%0d want %h 22 2",
                     reg_at(0), reg_at(1), ptr, m_regs[0]);
        end
        vectors++;
        if (bus_wr_cnt - c0 != 1) begin
            miscompares++;
            $display("FAIL wp_pulses: got %0d want 1", bus_wr_cnt - c0);
        end
        hw_we = 1'b1;
        hw_addr = 3'd0;
        hw_wdata = 8'h3C;
        tick();
        vectors++;
        if (reg_at(0) !== 8'h3C) begin
            miscompares++;
            $display("FAIL wp_hw_bypass: got %h want 3c", reg_at(0));
        end
        wp_mask = '0;
    endtask
`endif

    initial begin
        test_reset();
        test_ptr_write();
        test_ptr_read();
        test_collision();
        test_oversized_ptr();
        test_start_with_rx();
        test_stop_with_rx();
        test_stop_with_tx();
        test_hw_during_load();
        test_random();
        test_reset_mid_rd();
`ifdef I2C_REGMAP_WP_EN
        test_write_protect();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
